mig_ui_responder: RTL



---
 rtl/mig_ui_responder.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/mig_ui_responder.sv
`timescale 1ns/1ps
// apb_mig_pkg: shared payload types for the APB-to-MIG path.
//   data_t     : one memory word as seen on the MIG user interface
//   mig_addr_t : byte address on the MIG user interface
package apb_mig_pkg;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] mig_addr_t;
endpackage

// mig_ui_responder: stands in for the MIG core behind the user interface.
// A word-addressed on-chip memory answers commands while the block mimics
// controller calibration, periodic refresh stalls and a fixed read latency.
//   sys_clk_i / sys_reset_ni : single clock, async active-low reset
//   ui_clk_o / ui_reset_no   : UI clock (copy of sys_clk_i), UI reset (high after calibration)
//   en_i, w_en_i, addr_i     : command request, 1=write / 0=read, byte address
//   data_i, strb_i           : write data and byte enables
//   ready_o, w_ready_o       : command / write data can be accepted
//   valid_o, data_o          : one-cycle read-data pulse, read data (held until next read)
module mig_ui_responder
    import apb_mig_pkg::*;
#(
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned CALIB_CYCLES   = 16,
    parameter int unsigned RD_LATENCY     = 4,
    parameter int unsigned REFRESH_PERIOD = 256,
    parameter int unsigned REFRESH_CYCLES = 8
) (
    input  logic                        sys_clk_i,
    input  logic                        sys_reset_ni,
    output logic                        ui_clk_o,
    output logic                        ui_reset_no,
    input  logic                        en_i,
    input  logic                        w_en_i,
    input  mig_addr_t                   addr_i,
    input  data_t                       data_i,
    input  logic [$bits(data_t)/8-1:0]  strb_i,
    output logic                        ready_o,
    output logic                        w_ready_o,
    output logic                        valid_o,
    output data_t                       data_o
);

    localparam int unsigned W       = $bits(data_t);
    localparam int unsigned B       = W / 8;
    localparam int unsigned OFF_W   = (B > 1) ? $clog2(B) : 0;
    localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_MAX0 = (CALIB_CYCLES > RD_LATENCY) ? CALIB_CYCLES : RD_LATENCY;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > REFRESH_CYCLES) ? CNT_MAX0 : REFRESH_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned REF_W   = $clog2(REFRESH_PERIOD + 1);

    typedef enum logic [1:0] {
        ST_CALIB   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_READ    = 2'd2,
        ST_REFRESH = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic               pending_q, pending_d;
    logic               rdy_q, rdy_d;
    logic               ui_rst_q, ui_rst_d;
    logic               valid_q, valid_d;
    data_t              data_q, data_d;
    data_t              rd_word_q, rd_word_d;

    logic [W-1:0]       mem_q [DEPTH];
    logic [IDX_W-1:0]   idx;
    data_t              rd_word_c;
    logic               wr_acc;
    logic               rd_acc;
    logic               ref_expire;
    logic               unused_addr;

    // Word index: byte-offset bits dropped, upper bits wrap modulo DEPTH.
    assign idx         = addr_i[OFF_W +: IDX_W];
    assign unused_addr = ^addr_i;
    assign rd_word_c   = mem_q[idx];

    // rdy_q is only set when the next state is IDLE, so it implies state_q == IDLE.
    assign wr_acc = en_i & w_en_i & rdy_q;
    assign rd_acc = en_i & ~w_en_i & rdy_q;

    // Byte-masked write port; contents are intentionally not reset.
    always_ff @(posedge sys_clk_i) begin
        for (int k = 0; k < int'(B); k++) begin
            if (wr_acc && strb_i[k]) begin
                mem_q[idx][8*k +: 8] <= data_i[8*k +: 8];
            end
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ref_cnt_d  = ref_cnt_q;
        pending_d  = pending_q;
        ui_rst_d   = ui_rst_q;
        valid_d    = 1'b0;
        data_d     = data_q;
        rd_word_d  = rd_word_q;
        ref_expire = 1'b0;

        // Refresh period counter: idle during calibration, free-running afterwards.
        if (state_q == ST_CALIB) begin
            ref_cnt_d = '0;
        end else if (ref_cnt_q == REF_W'(REFRESH_PERIOD - 1)) begin
            ref_cnt_d  = '0;
            ref_expire = 1'b1;
        end else begin
            ref_cnt_d = ref_cnt_q + REF_W'(1);
        end

        case (state_q)
            ST_CALIB: begin
                if (cnt_q == CNT_W'(CALIB_CYCLES - 1)) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    ui_rst_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_IDLE: begin
                if (rd_acc && (RD_LATENCY > 1)) begin
                    // Read first; a refresh falling due now waits for it to finish.
                    state_d   = ST_READ;
                    cnt_d     = CNT_W'(1);
                    rd_word_d = rd_word_c;
                    if (ref_expire) begin
                        pending_d = 1'b1;
                    end
                end else begin
                    if (rd_acc) begin
                        valid_d = 1'b1;
                        data_d  = rd_word_c;
                    end
                    // A refresh falling due while idle starts at once so the stall is exact.
                    if (pending_q || ref_expire) begin
                        state_d   = ST_REFRESH;
                        cnt_d     = '0;
                        pending_d = 1'b0;
                    end
                end
            end

            ST_READ: begin
                if (ref_expire) begin
                    pending_d = 1'b1;
                end
                if (cnt_q == CNT_W'(RD_LATENCY - 1)) begin
                    valid_d = 1'b1;
                    data_d  = rd_word_q;
                    cnt_d   = '0;
                    if (pending_q || ref_expire) begin
                        state_d   = ST_REFRESH;
                        pending_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_REFRESH: begin
                if (ref_expire) begin
                    pending_d = 1'b1;
                end
                if (cnt_q == CNT_W'(REFRESH_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_CALIB;
                cnt_d   = '0;
            end
        endcase

        // Ready is registered from the upcoming state so it has no input-to-output path.
        rdy_d = (state_d == ST_IDLE) && !pending_d;
    end

    // State and output registers.
    always_ff @(posedge sys_clk_i or negedge sys_reset_ni) begin
        if (!sys_reset_ni) begin
            state_q   <= ST_CALIB;
            cnt_q     <= '0;
            ref_cnt_q <= '0;
            pending_q <= 1'b0;
            rdy_q     <= 1'b0;
            ui_rst_q  <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            rd_word_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ref_cnt_q <= ref_cnt_d;
            pending_q <= pending_d;
            rdy_q     <= rdy_d;
            ui_rst_q  <= ui_rst_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            rd_word_q <= rd_word_d;
        end
    end

    assign ui_clk_o    = sys_clk_i;
    assign ui_reset_no = ui_rst_q;
    assign ready_o     = rdy_q;
    assign w_ready_o   = rdy_q;
    assign valid_o     = valid_q;
    assign data_o      = data_q;

endmodule
